// File: rtl/noc_port_allocator.sv
// Wormhole output-port allocator: round-robin head-flit arbitration with the lock held until the tail flit.
// Define NOC_ALLOC_TIMEOUT_EN to add a watchdog that force-releases a lock stalled for TIMEOUT_CYCLES.
module noc_port_allocator #(
  parameter int NUM_PORTS      = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         noc_clk,
  input  logic                         noc_rst_n,
  input  logic [NUM_PORTS-1:0]         request,
  input  logic [NUM_PORTS-1:0]         start_of_packet,
  input  logic [NUM_PORTS-1:0]         end_of_packet,
  input  logic                         downstream_free,
  input  logic                         flit_fire,
  output logic [NUM_PORTS-1:0]         grant,
  output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
  output logic                         busy,
  output logic                         timeout_err,
  output logic                         state_dbg
);
  localparam int IDX_W = $clog2(NUM_PORTS);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 busy_q, busy_d;
  logic [IDX_W-1:0]     next_ptr;
  logic [NUM_PORTS-1:0] eligible;
  logic                 tail_fire;
  logic                 wd_expire;
  logic                 found;
  logic [IDX_W-1:0]     sel_idx;
  int                   scan_p;

  // flit_fire means one flit of the granted port moved this cycle; the allocator
  // never back-pressures it, it only watches for the tail to drop the lock.
  assign eligible  = request & start_of_packet & {NUM_PORTS{downstream_free}};
  assign tail_fire = flit_fire & (|(end_of_packet & grant_q));
  assign next_ptr  = (grant_idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx_q + IDX_W'(1);

  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    scan_p  = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_p = int'(rr_ptr_q) + k;
      if (scan_p >= NUM_PORTS) scan_p = scan_p - NUM_PORTS;
      if (!found && eligible[scan_p]) begin
        found   = 1'b1;
        sel_idx = IDX_W'(scan_p);
      end
    end
  end

`ifdef NOC_ALLOC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_err_q;

  // Counter sits at zero outside LOCKED, so every lock starts from a clean count.
  always_comb begin
    wd_cnt_d  = '0;
    wd_expire = 1'b0;
    if (state_q == LOCKED && !flit_fire) begin
      if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) wd_expire = 1'b1;
      else                                       wd_cnt_d  = wd_cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= wd_expire;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  if (NUM_PORTS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("noc_port_allocator: NUM_PORTS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d          = LOCKED;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          grant_idx_d      = sel_idx;
          busy_d           = 1'b1;
        end
      end
      LOCKED: begin
        if (tail_fire || wd_expire) begin
          state_d  = IDLE;
          grant_d  = '0;
          busy_d   = 1'b0;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      busy_q      <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign busy      = busy_q;
  assign state_dbg = (state_q == LOCKED);

endmodule
